// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the ADD/SUB ALU and its command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01
    } alu_op_e;

    // op is kept as raw bits so illegal encodings travel to the ALU unchanged
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10
    } seq_state_e;

    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op != OP_ADD) && (op != OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : Synchronous FIFO, wrap-around pointers with an extra MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Buffers tagged ALU commands, drives the external ALU from the
//                FIFO head and registers tagged results for a downstream sink.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic [OP_W-1:0]          in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [OP_W-1:0]          alu_opcode,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    typedef struct packed {
        alu_cmd_t         cmd;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t     w_push_entry;
    entry_t     w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_load;
    logic       w_drained;
    seq_state_e r_state;

    assign w_push_entry = '{cmd: '{a: in_a, b: in_b, op: in_op}, tag: in_tag};

    // Full blocks acceptance even when a pop happens on the same edge
    assign in_ready = !w_full && !rst;
    assign w_push   = in_valid && in_ready;
    assign w_load   = !w_empty && (!out_valid || out_ready);

    alu_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_load),
        .full      (w_full),
        .empty     (w_empty),
        .count     (count),
        .head      (w_head)
    );

    assign alu_a      = w_empty ? '0 : w_head.cmd.a;
    assign alu_b      = w_empty ? '0 : w_head.cmd.b;
    assign alu_opcode = w_empty ? '0 : w_head.cmd.op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
        end else if (w_load) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_tag    <= w_head.tag;
            out_zero   <= (alu_result == '0);
            out_err    <= is_illegal_op(w_head.cmd.op);
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Nothing left buffered, nothing arriving, and the output slot frees up
    assign w_drained = w_empty && !w_push && (!out_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_push) r_state <= RUN;
                end
                RUN: begin
                    if (out_valid && !out_ready && !w_empty) r_state <= STALL;
                    else if (w_drained)                      r_state <= IDLE;
                end
                STALL: begin
                    if (out_ready) r_state <= RUN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Scoreboard bench for alu_cmd_sequencer with a behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [1:0]       alu_opcode;
    logic [7:0]       alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_err;
    logic [CW-1:0]    count;

    typedef struct {
        logic [7:0]       res;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             err;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    exp_t e;
    bit   held_v      = 1'b0;
    bit   stream_mode = 1'b0;
    int   stream_seen = 0;
    int   n_checks    = 0;
    int   n_pass      = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_err    (out_err),
        .count      (count)
    );

    // External combinational ALU
    always_comb begin
        case (alu_opcode)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    function automatic exp_t ref_model(input int a, input int b, input int op, input int tag);
        exp_t r;
        int   v;
        if (op == 0)      v = (a + b) % 256;
        else if (op == 1) v = (a - b + 256) % 256;
        else              v = 0;
        r.res  = 8'(v);
        r.tag  = TAG_W'(tag);
        r.zero = (v == 0);
        r.err  = (op >= 2);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic check_reset(input string tagname);
        check({tagname, "_out_valid"},  out_valid,  0);
        check({tagname, "_out_result"}, out_result, 0);
        check({tagname, "_out_tag"},    out_tag,    0);
        check({tagname, "_out_zero"},   out_zero,   0);
        check({tagname, "_out_err"},    out_err,    0);
        check({tagname, "_alu_a"},      alu_a,      0);
        check({tagname, "_alu_b"},      alu_b,      0);
        check({tagname, "_alu_opcode"}, alu_opcode, 0);
        check({tagname, "_in_ready"},   in_ready,   0);
        check({tagname, "_count"},      count,      0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input int tag);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = TAG_W'(tag);
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for 100 cycles, required 1");
        end
        in_valid = 1'b0;
    endtask

    // Monitor: samples on the falling edge, between active edges
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            check("in_ready_vs_count", in_ready, (count < DEPTH));
            if (stream_mode) begin
                check("stream_count_le1", (count <= 1), 1);
                if (stream_seen > 0 && stream_seen < 16) check("stream_no_bubble", out_valid, 1);
            end
            if (held_v) begin
                check("stall_valid",  out_valid,  1);
                check("stall_result", out_result, held.res);
                check("stall_tag",    out_tag,    held.tag);
                check("stall_zero",   out_zero,   held.zero);
                check("stall_err",    out_err,    held.err);
            end
            held_v = out_valid && !out_ready;
            if (held_v) begin
                held.res  = out_result;
                held.tag  = out_tag;
                held.zero = out_zero;
                held.err  = out_err;
            end
            if (in_valid && in_ready) sb.push_back(ref_model(in_a, in_b, in_op, in_tag));
            if (out_valid && out_ready) begin
                if (stream_mode) stream_seen++;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: output tag %0h present, required no pending result", out_tag);
                end else begin
                    e = sb.pop_front();
                    check("sb_result", out_result, e.res);
                    check("sb_tag",    out_tag,    e.tag);
                    check("sb_zero",   out_zero,   e.zero);
                    check("sb_err",    out_err,    e.err);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #1;
        check_reset("reset");
        idle(3);
        rst = 1'b0;

        // Single ADD: result visible one edge after the accepting edge
        out_ready = 1'b1;
        send(8'h05, 8'h03, 2'b00, 1);
        check("t1_valid_after_e0", out_valid, 0);
        idle(1);
        check("t1_valid_after_e1", out_valid, 1);
        check("t1_result", out_result, 8'h08);
        check("t1_tag", out_tag, 1);
        idle(3);

        // SUB underflow and ADD wrap
        send(8'h03, 8'h05, 2'b01, 2);
        send(8'hFF, 8'h01, 2'b00, 3);
        idle(4);

        // Illegal opcode then ordinary ADD
        send(8'hAA, 8'($urandom), 2'b11, 4);
        send(8'($urandom), 8'($urandom), 2'b00, 5);
        idle(4);

        // Stall with full FIFO, then drain
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 1)), t);
        idle(3);
        check("t3_count_full", count, DEPTH);
        check("t3_in_ready", in_ready, 0);
        check("t3_out_valid", out_valid, 1);
        check("t3_head_tag", out_tag, 0);
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("t3_drain_rate", out_valid, 1);
        end
        idle(3);
        check("t3_drained", count, 0);

        // Back-to-back streaming
        stream_seen = 0;
        stream_mode = 1'b1;
        for (int t = 0; t < 16; t++) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 1)), t);
        idle(4);
        stream_mode = 1'b0;
        check("t5_stream_results", stream_seen, 16);

        // Reset in the middle of buffered work
        out_ready = 1'b0;
        for (int t = 0; t < 4; t++) send(8'($urandom), 8'($urandom), 2'b00, t);
        check("t6_count_before", count, 3);
        check("t6_valid_before", out_valid, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("t6_reset");
        sb.delete();
        idle(2);
        rst       = 1'b0;
        out_ready = 1'b1;
        send(8'h10, 8'h20, 2'b00, 9);
        idle(1);
        check("t6_first_valid", out_valid, 1);
        check("t6_first_tag", out_tag, 9);
        idle(3);

        // Randomised traffic with random backpressure
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_op     = 2'($urandom_range(0, 3));
            in_tag    = c[TAG_W-1:0];
            out_ready = ($urandom_range(0, 3) != 0);
            idle(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) idle(1);
        idle(2);
        check("final_sb_empty", sb.size(), 0);
        check("final_count", count, 0);
        check("final_out_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
